sort32_loader: RTL and testbench
================================

Name: sort32_loader

Overview:
- Upstream feeder for the 32-element sorting network.
- Accepts a serial stream of 32-bit keys over a valid/ready handshake and packs them into the flat 1024-bit vector the network consumes. Word i occupies bits [(i+1)*32-1 : i*32].
- Double-buffered (ping-pong): one bank fills while the other is held stable for the downstream sort/capture stage, so back-to-back frames stream without bubbles.

Parameters:
- N, 32, elements per frame; fixed by the network (only 32 is supported).
- W, 32, key width in bits.
- PAD_VALUE, 32'hFFFF_FFFF, filler written into unused slots (reset contents and early-closed frames).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous reset, active-high.
- in_data  in  W  key word.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader can accept a word this cycle.
- in_last  in  1  closes the frame early (present only with SORT32_LOADER_LAST_EN).
- vec_out  out  N*W  packed frame for the sort network.
- vec_valid  out  1  vec_out holds a complete frame.
- vec_ready  in  1  consumer has taken vec_out.
- vec_count  out  6  number of real keys in vec_out, 1..32.

Behaviour:
- Clocking and reset: one clock (clk); reset rst is synchronous and active-high.
- State:
  - Two banks B0/B1, each holding N words, a 6-bit count and a full flag.
  - wr_sel and rd_sel are 1-bit bank pointers.
  - wr_idx is a 5-bit write index.
- Reset (rst=1 at a clock edge):
  - full[1:0]=0, wr_sel=0, rd_sel=0, wr_idx=0.
  - All bank words = PAD_VALUE; counts = 0.
  - Outputs after reset: in_ready=1, vec_valid=0, vec_count=0, vec_out = all PAD_VALUE.
  - Reset mid-frame discards partial and held frames; nothing is emitted.
- Write side:
  - in_ready = !full[wr_sel]. This is combinational from registers only, with no path from in_valid.
  - On accept (in_valid && in_ready): bank[wr_sel][wr_idx] <= in_data.
  - Close condition: wr_idx==31, or in_last=1 with the feature enabled.
    - On close: full[wr_sel]<=1, count[wr_sel]<=wr_idx+1, wr_sel flips, wr_idx<=0.
    - Otherwise: wr_idx<=wr_idx+1.
  - in_valid with in_ready=0: no state change. The source must hold its data.
- Read side:
  - vec_valid = full[rd_sel]; vec_out = bank[rd_sel] words; vec_count = count[rd_sel] (0 when not valid).
  - On vec_valid && vec_ready: full[rd_sel]<=0, rd_sel flips.
  - vec_out is stable and unchanged while vec_valid=1 and vec_ready=0.
- Latency: the frame closes on edge k; vec_valid=1 after edge k, provided the read side is at that bank.
- Throughput: one word per cycle sustained while the consumer releases each frame within 32 cycles.
- Simultaneous events:
  - A close on one bank and a release of the other bank in the same cycle are both applied.
  - A release of bank X in cycle t makes in_ready for bank X high at t+1, not combinationally.
- Full condition: both banks full gives in_ready=0 until a release.
- Pointer wrap: wr_sel and rd_sel wrap 1→0. wr_idx never exceeds 31.

Optional Feature:
- Macro: SORT32_LOADER_LAST_EN.
- Enabled:
  - The in_last port exists. An accepted word with in_last=1 closes the frame at wr_idx+1 keys.
  - In the same edge, slots wr_idx+1..31 of that bank are written PAD_VALUE.
  - vec_count = real key count.
  - in_last on slot 31 behaves as a normal close.
- Disabled:
  - No in_last port; every frame has exactly 32 keys.
  - vec_count = 32 whenever vec_valid=1.
  - No pad writes after reset.

Test Plan:
- Reset, then stream keys 0..31 with vec_ready=0 → vec_valid=1 one cycle after key 31. Word i = i, vec_count=32, in_ready stays 1 for the second bank.
- Stream 96 keys continuously with vec_ready=0 → in_ready drops after key 63. Assert vec_ready for 1 cycle → frame 0 released, in_ready=1 next cycle, frame 1 presented (keys 32..63).
- Continuous source plus vec_ready=1 each valid cycle → 4 frames in 128+1 cycles with no in_ready bubbles. Contents match order.
- Random in_valid/vec_ready stalls over 1000 keys → every key appears exactly once, in order. vec_out is constant during backpressure.
- Assert rst mid-frame after 10 keys with a full bank held → vec_valid=0, in_ready=1. The next 32 keys form a clean frame.
- (SORT32_LOADER_LAST_EN) 5 keys, with in_last on the 5th → vec_count=5, words 5..31 = 32'hFFFF_FFFF. The next frame starts at slot 0.

Source files
------------

// File: rtl/sort32_loader.sv
// sort32_loader
// Serial-to-parallel feeder for the 32-element sorting network. Keys arrive
// one per cycle over a valid/ready handshake. They are packed into one of two
// banks (ping-pong), so one bank fills while the other is held stable for the
// downstream network. Word i of a frame sits at vec_out[(i+1)*W-1 : i*W].
//
// Optional feature macro: SORT32_LOADER_LAST_EN
//   When defined, the in_last input is present. An accepted word with in_last=1
//   closes the frame early, and the unused upper slots are refilled with PAD_VALUE.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous reset, active-high
//   in_data    key word
//   in_valid   in_data is valid
//   in_ready   loader can accept a word this cycle (registers only)
//   in_last    early frame close (SORT32_LOADER_LAST_EN only)
//   vec_out    packed frame, N words of W bits
//   vec_valid  vec_out holds a complete frame
//   vec_ready  consumer has taken vec_out
//   vec_count  real keys in vec_out (0 when not valid)

module sort32_loader #(
    parameter int             N         = 32,
    parameter int             W         = 32,
    parameter logic [W-1:0]   PAD_VALUE = 32'hFFFF_FFFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     in_data,
    input  logic             in_valid,
    output logic             in_ready,
`ifdef SORT32_LOADER_LAST_EN
    input  logic             in_last,
`endif
    output logic [N*W-1:0]   vec_out,
    output logic             vec_valid,
    input  logic             vec_ready,
    output logic [5:0]       vec_count
);

    logic [W-1:0] mem   [2][N];
    logic [5:0]   count [2];
    logic [1:0]   full;
    logic         wr_sel;
    logic         rd_sel;
    logic [4:0]   wr_idx;

    logic         accept;
    logic         early;
    logic         close;
    logic         rd_take;

`ifdef SORT32_LOADER_LAST_EN
    assign early = in_last;
`else
    assign early = 1'b0;
`endif

    assign in_ready  = ~full[wr_sel];
    assign accept    = in_valid & in_ready;
    assign close     = accept & ((wr_idx == 5'd31) | early);
    assign vec_valid = full[rd_sel];
    assign vec_count = full[rd_sel] ? count[rd_sel] : 6'd0;
    assign rd_take   = vec_valid & vec_ready;

    always_comb begin
        vec_out = '0;
        for (int i = 0; i < N; i++) begin
            vec_out[i*W +: W] = mem[rd_sel][i];
        end
    end

    // A close always targets the empty bank and a release always targets the
    // full one, so both can land in the same cycle on different full[] bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            full   <= 2'b00;
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
            wr_idx <= 5'd0;
            for (int b = 0; b < 2; b++) begin
                count[b] <= 6'd0;
                for (int s = 0; s < N; s++) begin
                    mem[b][s] <= PAD_VALUE;
                end
            end
        end else begin
            if (accept) begin
                mem[wr_sel][wr_idx] <= in_data;
                if (close) begin
                    full[wr_sel]  <= 1'b1;
                    count[wr_sel] <= {1'b0, wr_idx} + 6'd1;
                    wr_sel        <= ~wr_sel;
                    wr_idx        <= 5'd0;
`ifdef SORT32_LOADER_LAST_EN
                    // Scrub stale keys above the last real one so the network
                    // sorts pads to the top instead of an old frame's data.
                    if (early) begin
                        for (int s = 0; s < N; s++) begin
                            if (s > int'(wr_idx)) begin
                                mem[wr_sel][s] <= PAD_VALUE;
                            end
                        end
                    end
`endif
                end else begin
                    wr_idx <= wr_idx + 5'd1;
                end
            end
            if (rd_take) begin
                full[rd_sel] <= 1'b0;
                rd_sel       <= ~rd_sel;
            end
        end
    end

endmodule

// File: tb/tb_sort32_loader.sv
// Directed bench for sort32_loader: reset state, single frame fill, double-bank
// backpressure, sustained throughput, patterned stalls with a scoreboard,
// mid-frame reset, and (with SORT32_LOADER_LAST_EN) early frame close.

module tb_sort32_loader;

    localparam logic [31:0] PAD = 32'hFFFF_FFFF;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
`ifdef SORT32_LOADER_LAST_EN
    logic          in_last = 1'b0;
`endif
    logic [1023:0] vec_out;
    logic          vec_valid;
    logic          vec_ready = 1'b0;
    logic [5:0]    vec_count;

    int checks   = 0;
    int failures = 0;

    logic          acc;
    logic          tk;
    logic          held_v;
    logic [1023:0] held;
    int            bubbles, frames, ferr, n_src, n_exp, cerr, serr;

    sort32_loader dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
`ifdef SORT32_LOADER_LAST_EN
        .in_last   (in_last),
`endif
        .vec_out   (vec_out),
        .vec_valid (vec_valid),
        .vec_ready (vec_ready),
        .vec_count (vec_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic take();
        vec_ready = 1'b1;
        cyc();
        vec_ready = 1'b0;
    endtask

    function automatic logic [31:0] word(input int j);
        return vec_out[j*32 +: 32];
    endfunction

    function automatic int frame_err(input logic [31:0] base);
        int e = 0;
        for (int j = 0; j < 32; j++) if (word(j) !== base + j) e++;
        return e;
    endfunction

    function automatic int pad_err(input int from);
        int e = 0;
        for (int j = from; j < 32; j++) if (word(j) !== PAD) e++;
        return e;
    endfunction

    initial begin
        // Reset
        cyc();
        cyc();
        rst = 1'b0;
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_vec_valid", {31'd0, vec_valid}, 32'd0);
        chk("reset_vec_count", {26'd0, vec_count}, 32'd0);
        chk("reset_pad_words", pad_err(0), 32'd0);

        // One frame 0..31, consumer idle
        in_valid = 1'b1;
        for (int k = 0; k < 32; k++) begin
            in_data = k;
            cyc();
        end
        in_valid = 1'b0;
        chk("f0_vec_valid", {31'd0, vec_valid}, 32'd1);
        chk("f0_vec_count", {26'd0, vec_count}, 32'd32);
        chk("f0_words", frame_err(0), 32'd0);
        chk("f0_in_ready_bank1", {31'd0, in_ready}, 32'd1);

        // Second bank fills, then the source stalls against two full banks
        in_valid = 1'b1;
        for (int k = 32; k < 64; k++) begin
            in_data = k;
            cyc();
        end
        chk("both_full_in_ready", {31'd0, in_ready}, 32'd0);
        in_data = 64;
        cyc();
        cyc();
        chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        chk("stall_hold_words", frame_err(0), 32'd0);
        vec_ready = 1'b1;
        chk("release_cycle_in_ready", {31'd0, in_ready}, 32'd0);
        cyc();
        vec_ready = 1'b0;
        chk("after_release_in_ready", {31'd0, in_ready}, 32'd1);
        chk("f1_vec_valid", {31'd0, vec_valid}, 32'd1);
        chk("f1_words", frame_err(32), 32'd0);
        for (int k = 64; k < 96; k++) begin
            in_data = k;
            cyc();
        end
        in_valid = 1'b0;
        chk("refill_in_ready", {31'd0, in_ready}, 32'd0);
        take();
        chk("f2_words", frame_err(64), 32'd0);
        chk("f2_vec_count", {26'd0, vec_count}, 32'd32);
        take();
        chk("drained_vec_valid", {31'd0, vec_valid}, 32'd0);
        chk("drained_vec_count", {26'd0, vec_count}, 32'd0);
        chk("drained_in_ready", {31'd0, in_ready}, 32'd1);

        // Sustained throughput: 128 keys, consumer always ready
        vec_ready = 1'b1;
        bubbles = 0;
        frames = 0;
        ferr = 0;
        for (int c = 0; c < 130; c++) begin
            if (c < 128) begin
                in_valid = 1'b1;
                in_data = 1000 + c;
                if (!in_ready) bubbles++;
            end else begin
                in_valid = 1'b0;
            end
            cyc();
            if (vec_valid) begin
                ferr += frame_err(1000 + frames * 32);
                frames++;
            end
        end
        vec_ready = 1'b0;
        chk("tput_bubbles", bubbles, 32'd0);
        chk("tput_frames", frames, 32'd4);
        chk("tput_contents", ferr, 32'd0);

        // Patterned stalls on both sides, 1024 keys, in-order scoreboard
        n_src = 0;
        n_exp = 0;
        cerr = 0;
        serr = 0;
        held_v = 1'b0;
        held = '0;
        for (int c = 0; c < 6000 && n_exp < 1024; c++) begin
            in_valid = (n_src < 1024) && ((c % 5) != 2);
            in_data = 20000 + n_src;
            vec_ready = ((c % 7) < 3);
            if (held_v && vec_valid && vec_out !== held) serr++;
            acc = in_valid && in_ready;
            tk = vec_valid && vec_ready;
            if (tk) begin
                cerr += frame_err(20000 + n_exp);
                held_v = 1'b0;
            end else if (vec_valid) begin
                held = vec_out;
                held_v = 1'b1;
            end
            cyc();
            if (acc) n_src++;
            if (tk) n_exp += 32;
        end
        in_valid = 1'b0;
        vec_ready = 1'b0;
        chk("stall_keys_sent", n_src, 32'd1024);
        chk("stall_keys_seen", n_exp, 32'd1024);
        chk("stall_contents", cerr, 32'd0);
        chk("stall_backpressure_stable", serr, 32'd0);

        // Reset with one held frame plus 10 keys of a partial frame
        in_valid = 1'b1;
        for (int k = 0; k < 42; k++) begin
            in_data = 32'h300 + k;
            cyc();
        end
        in_valid = 1'b0;
        chk("prerst_vec_valid", {31'd0, vec_valid}, 32'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("midrst_vec_valid", {31'd0, vec_valid}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_vec_count", {26'd0, vec_count}, 32'd0);
        chk("midrst_pad_words", pad_err(0), 32'd0);
        in_valid = 1'b1;
        for (int k = 0; k < 32; k++) begin
            in_data = 32'h500 + k;
            cyc();
        end
        in_valid = 1'b0;
        chk("postrst_vec_valid", {31'd0, vec_valid}, 32'd1);
        chk("postrst_words", frame_err(32'h500), 32'd0);
        chk("postrst_vec_count", {26'd0, vec_count}, 32'd32);
        take();
        chk("postrst_released", {31'd0, vec_valid}, 32'd0);

`ifdef SORT32_LOADER_LAST_EN
        // Fill bank1 with real data first, so the early close below must pad over stale keys in bank0.
        in_valid = 1'b1;
        for (int k = 0; k < 32; k++) begin
            in_data = 32'h800 + k;
            cyc();
        end
        in_valid = 1'b0;
        take();
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_data = 32'h900 + k;
            in_last = (k == 4);
            cyc();
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        chk("last5_vec_valid", {31'd0, vec_valid}, 32'd1);
        chk("last5_vec_count", {26'd0, vec_count}, 32'd5);
        chk("last5_word0", word(0), 32'h900);
        chk("last5_word4", word(4), 32'h904);
        chk("last5_pad_words", pad_err(5), 32'd0);
        chk("last5_in_ready", {31'd0, in_ready}, 32'd1);
        take();
        in_valid = 1'b1;
        in_data = 32'hA00;
        in_last = 1'b1;
        cyc();
        in_valid = 1'b0;
        in_last = 1'b0;
        chk("last1_vec_count", {26'd0, vec_count}, 32'd1);
        chk("last1_word0", word(0), 32'hA00);
        chk("last1_pad_words", pad_err(1), 32'd0);
        take();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
